// File: rtl/sw_key_input_port.sv
// sw_key_input_port: memory-mapped input port for slide switches and push keys.
// Two-flop synchronizers, per-bit debounce counters, sticky key-press flags
// with a key interrupt line, and a registered read port.
// Optional build macro SWKEY_SW_CHANGE_EN adds a sticky SW_CHANGE register
// at word offset 4 and drives STATUS bit1 from it.
module sw_key_input_port #(
   parameter logic [31:0] BASE_ADDR       = 32'h000000C0,
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [9:0]  sw,
   input  logic [3:0]  key,
   input  logic [31:0] addr,
   input  logic        rd_en,
   input  logic        we,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        key_irq
);

   // bits [9:0] are switches, bits [13:10] are keys (1 = pressed)
   localparam int unsigned NB = 14;
   localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [9:0]    sw_s1, sw_s2;
   logic [3:0]    key_s1, key_s2;
   logic [NB-1:0] syn, deb, deb_nxt;
   logic [CW-1:0] cnt     [NB];
   logic [CW-1:0] cnt_nxt [NB];
   logic [3:0]    key_edge, edge_nxt, key_press, edge_clr;
   logic          sel, rd_edge_sel, wr_edge_sel;
   logic [2:0]    off;
   logic [31:0]   rd_word;
   logic          chg_any;
   logic          unused_bits;

   assign unused_bits = ^{addr[1:0], wdata[31:4]};

   // two-flop synchronizers; keys idle high (released)
   always_ff @(posedge clock) begin
      if (reset) begin
         sw_s1  <= '0;
         sw_s2  <= '0;
         key_s1 <= '1;
         key_s2 <= '1;
      end else begin
         sw_s1  <= sw;
         sw_s2  <= sw_s1;
         key_s1 <= key;
         key_s2 <= key_s1;
      end
   end

   assign syn = {~key_s2, sw_s2};

   // per-bit debounce: count consecutive differing cycles, flip at CNT_MAX
   always_comb begin
      deb_nxt = deb;
      for (int unsigned i = 0; i < NB; i++) begin
         cnt_nxt[i] = '0;
         if (syn[i] != deb[i]) begin
            if (cnt[i] == CNT_MAX) deb_nxt[i] = syn[i];
            else                   cnt_nxt[i] = cnt[i] + 1'b1;
         end
      end
   end

   // debounced state and counters
   always_ff @(posedge clock) begin
      if (reset) begin
         deb <= '0;
         for (int unsigned i = 0; i < NB; i++) cnt[i] <= '0;
      end else begin
         deb <= deb_nxt;
         for (int unsigned i = 0; i < NB; i++) cnt[i] <= cnt_nxt[i];
      end
   end

   assign sel         = (addr[31:5] == BASE_ADDR[31:5]);
   assign off         = addr[4:2];
   assign rd_edge_sel = rd_en && sel && (off == 3'd2);
   assign wr_edge_sel = we && sel && (off == 3'd2);
   assign key_press   = deb_nxt[13:10] & ~deb[13:10];

   // clears are applied first so a press landing in the same cycle survives
   assign edge_clr = ({4{rd_edge_sel}} & key_edge) | ({4{wr_edge_sel}} & wdata[3:0]);
   assign edge_nxt = (key_edge & ~edge_clr) | key_press;

`ifdef SWKEY_SW_CHANGE_EN
   logic [9:0] sw_chg, chg_nxt;

   assign chg_nxt = ((rd_en && sel && (off == 3'd4)) ? 10'd0 : sw_chg)
                  | (deb_nxt[9:0] ^ deb[9:0]);
   assign chg_any = |sw_chg;

   // sticky switch-change flags, cleared by reading offset 4
   always_ff @(posedge clock) begin
      if (reset) sw_chg <= '0;
      else       sw_chg <= chg_nxt;
   end
`else
   assign chg_any = 1'b0;
`endif

   // read mux over the register window; unselected or unmapped reads give 0
   always_comb begin
      rd_word = '0;
      if (sel) begin
         case (off)
            3'd0: rd_word = {22'b0, deb[9:0]};
            3'd1: rd_word = {28'b0, deb[13:10]};
            3'd2: rd_word = {28'b0, key_edge};
            3'd3: rd_word = {30'b0, chg_any, |key_edge};
`ifdef SWKEY_SW_CHANGE_EN
            3'd4: rd_word = {22'b0, sw_chg};
`endif
            default: rd_word = '0;
         endcase
      end
   end

   // sticky key flags, interrupt line and registered read data
   always_ff @(posedge clock) begin
      if (reset) begin
         key_edge <= '0;
         key_irq  <= 1'b0;
         rdata    <= '0;
      end else begin
         key_edge <= edge_nxt;
         key_irq  <= |edge_nxt;
         if (rd_en) rdata <= rd_word;
      end
   end

endmodule

// File: tb/tb_sw_key_input_port.sv
// tb_sw_key_input_port: directed scenarios plus randomized traffic, every
// cycle compared against a window-based behavioural model of the port.
module tb_sw_key_input_port;

   localparam logic [31:0] BASE = 32'h000000C0;
   localparam int unsigned DB   = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [9:0]  sw    = '0;
   logic [3:0]  key   = '1;
   logic [31:0] addr  = '0;
   logic        rd_en = 1'b0;
   logic        we    = 1'b0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        key_irq;

   sw_key_input_port #(
      .BASE_ADDR       (BASE),
      .DEBOUNCE_CYCLES (DB)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .sw      (sw),
      .key     (key),
      .addr    (addr),
      .rd_en   (rd_en),
      .we      (we),
      .wdata   (wdata),
      .rdata   (rdata),
      .key_irq (key_irq)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // model state: pin history, synced-sample window, debounced value, flags
   logic [13:0] m_hist [$];
   logic [13:0] m_syn  [$];
   logic [13:0] m_deb;
   logic [3:0]  m_edge;
   logic [9:0]  m_chg;
   logic [31:0] m_rdata;
   logic        m_irq;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // true when the last DB synced samples of bit b all equal v
   function automatic logic window_all(input int b, input logic v);
      if (m_syn.size() < DB) return 1'b0;
      foreach (m_syn[k]) if (m_syn[k][b] !== v) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_edge();
      logic [13:0] s, nd;
      logic [3:0]  press, e;
      logic [9:0]  swt, c;
      logic [31:0] word;
      logic        sel, chg_any;
      int unsigned off;
      if (reset) begin
         m_hist.delete();
         m_hist.push_back(14'd0);
         m_hist.push_back(14'd0);
         m_syn.delete();
         m_deb = '0; m_edge = '0; m_chg = '0; m_rdata = '0; m_irq = 1'b0;
         return;
      end
      // the value seen by the debouncer is the pin value from two edges back
      s = m_hist[m_hist.size() - 2];
      m_hist.push_back({~key, sw});
      if (m_hist.size() > 4) void'(m_hist.pop_front());
      m_syn.push_back(s);
      if (m_syn.size() > DB) void'(m_syn.pop_front());
      nd = m_deb;
      for (int b = 0; b < 14; b++)
         if (window_all(b, ~m_deb[b])) nd[b] = ~m_deb[b];
      press = nd[13:10] & ~m_deb[13:10];
      swt   = nd[9:0] ^ m_deb[9:0];
`ifdef SWKEY_SW_CHANGE_EN
      chg_any = |m_chg;
`else
      chg_any = 1'b0;
`endif
      sel  = (addr[31:5] == BASE[31:5]);
      off  = int'(addr[4:2]);
      word = 0;
      if (sel) begin
         case (off)
            0: word = 32'(m_deb[9:0]);
            1: word = 32'(m_deb[13:10]);
            2: word = 32'(m_edge);
            3: word = {30'd0, chg_any, |m_edge};
`ifdef SWKEY_SW_CHANGE_EN
            4: word = 32'(m_chg);
`endif
            default: word = 0;
         endcase
      end
      if (rd_en) m_rdata = word;
      e = m_edge;
      if (rd_en && sel && off == 2) e = 4'd0;
      if (we && sel && off == 2) e = e & ~wdata[3:0];
      e = e | press;
      c = m_chg;
      if (rd_en && sel && off == 4) c = 10'd0;
      c = c | swt;
`ifdef SWKEY_SW_CHANGE_EN
      m_chg = c;
`else
      m_chg = 10'd0;
`endif
      m_edge = e;
      m_irq  = |e;
      m_deb  = nd;
   endtask

   task automatic step();
      @(posedge clock);
      model_edge();
      #1;
      check("rdata", rdata, m_rdata);
      check("key_irq", {31'd0, key_irq}, {31'd0, m_irq});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_read(input int unsigned off);
      addr  = BASE + 32'(off * 4);
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
   endtask

   task automatic do_write(input int unsigned off, input logic [31:0] d);
      addr  = BASE + 32'(off * 4);
      wdata = d;
      we    = 1'b1;
      step();
      we    = 1'b0;
   endtask

   initial begin
      // reset with switches set and keys released
      sw = 10'b1010101010; key = 4'b1111; reset = 1'b1;
      idle(3);
      check("rst_rdata", rdata, 32'd0);
      check("rst_irq", {31'd0, key_irq}, 32'd0);
      reset = 1'b0;
      do_read(1);
      check("rst_key_state", rdata, 32'd0);
      sw = '0;
      idle(20);

      // switch debounce latency
      sw = 10'b1010101010;
      idle(5);
      do_read(0);
      check("sw_deb_early", rdata, 32'd0);
      do_read(0);
      check("sw_deb_done", rdata, 32'h2AA);
      idle(10);

      // short glitch is rejected
      key = 4'b1110;
      idle(3);
      key = 4'b1111;
      idle(10);
      do_read(1);
      check("glitch_state", rdata, 32'd0);
      do_read(2);
      check("glitch_edge", rdata, 32'd0);

      // long press propagates and sets the flag
      key = 4'b1110;
      idle(7);
      do_read(1);
      check("press_state", rdata, 32'd1);
      key = 4'b1111;
      idle(10);
      check("press_irq", {31'd0, key_irq}, 32'd1);
      do_read(2);
      check("press_edge", rdata, 32'd1);
      check("irq_after_clr", {31'd0, key_irq}, 32'd0);

      // clear-on-read of two flags
      key = 4'b1010;
      idle(8);
      key = 4'b1111;
      idle(10);
      do_read(2);
      check("cor_value", rdata, 32'd5);
      check("cor_irq", {31'd0, key_irq}, 32'd0);
      do_read(2);
      check("cor_second", rdata, 32'd0);

      // new press collides with a clearing read
      key = 4'b1110;
      idle(8);
      key = 4'b1111;
      idle(10);
      key = 4'b1011;
      idle(5);
      do_read(2);
      check("coll_rdata", rdata, 32'd1);
      check("coll_irq", {31'd0, key_irq}, 32'd1);
      key = 4'b1111;
      idle(10);
      do_write(2, 32'd4);
      check("wr_clr_irq", {31'd0, key_irq}, 32'd0);
      do_read(2);
      check("wr_clr_edge", rdata, 32'd0);

      // decode: unselected and unmapped reads leave flags alone
      key = 4'b1101;
      idle(8);
      key = 4'b1111;
      idle(10);
      addr = 32'h000000E0; rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      check("unsel_read", rdata, 32'd0);
      do_read(6);
      check("unmapped_read", rdata, 32'd0);
      do_read(2);
      check("edge_kept", rdata, 32'd2);

      // switch change flags
      do_read(4);
      for (int t = 0; t < 3; t++) begin
         sw = sw ^ 10'h3FF;
         idle(20);
      end
      do_read(4);
`ifdef SWKEY_SW_CHANGE_EN
      check("sw_change_all", rdata, 32'h3FF);
`else
      check("sw_change_absent", rdata, 32'd0);
`endif
      do_read(4);
      check("sw_change_cleared", rdata, 32'd0);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 9) == 0) sw[$urandom_range(0, 9)] = ~sw[$urandom_range(0, 9)];
         if ($urandom_range(0, 11) == 0) key[$urandom_range(0, 3)] = ~key[$urandom_range(0, 3)];
         rd_en = ($urandom_range(0, 3) == 0);
         we    = ($urandom_range(0, 7) == 0);
         wdata = $urandom;
         if ($urandom_range(0, 7) == 0) addr = $urandom;
         else addr = BASE | (32'($urandom_range(0, 7)) << 2);
         reset = ($urandom_range(0, 499) == 0);
         step();
      end
      reset = 1'b0; rd_en = 1'b0; we = 1'b0;
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sw_key_input_port.md
Name: sw_key_input_port

Overview:
- Input-side peripheral for the single-cycle computer: the receiving end of the sw/key stimulus the board or bench drives.
- Synchronizes and debounces the 10 slide switches and 4 push keys.
- Captures key-press events in sticky flags.
- Presents the values to the CPU as memory-mapped words, with a registered read port and a key-event interrupt line.

Parameters:
- BASE_ADDR, 32'h000000C0, byte address of the 8-word register window; low 5 bits ignored.
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before a debounced bit changes; minimum 2.

Ports:
- clock  input  1  system clock; all logic on its rising edge
- reset  input  1  synchronous, active-high reset
- sw  input  10  raw slide switches, asynchronous
- key  input  4  raw push keys, active-low (0 = pressed), asynchronous
- addr  input  32  CPU byte address
- rd_en  input  1  read strobe
- we  input  1  write strobe
- wdata  input  32  write data
- rdata  output  32  registered read data
- key_irq  output  1  registered; high while any sticky key-press flag is set

Behaviour:
- Reset (synchronous, checked first every cycle):
  - sw sync flops clear to 0; key sync flops set to 1 (released).
  - Debounced sw and key state clear to 0; all debounce counters clear to 0.
  - KEY_EDGE clears to 0; rdata and key_irq clear to 0.
- Reset applied mid-debounce or mid-read abandons the operation; no flag survives.
- Synchronizer: two flops per input bit. Key bits are inverted after sync, so internal 1 = pressed.
- Debounce, per bit:
  - The counter clears whenever the synced value equals the debounced value.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the bit still differs, the debounced bit takes the synced value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never propagates.
  - Latency from a stable pin change to the debounced change is 2 + DEBOUNCE_CYCLES cycles.
- Key edge: a debounced key bit going 0->1 (press) sets KEY_EDGE[i] in the same cycle. Release sets nothing.
- Decode:
  - Selected when addr[31:5] == BASE_ADDR[31:5]; word offset is addr[4:2].
  - Offsets: 0 SW_STATE {22'b0, sw_deb}; 1 KEY_STATE {28'b0, key_deb}; 2 KEY_EDGE {28'b0, flags}; 3 STATUS {30'b0, any_sw_change_flag, |KEY_EDGE}; 4 SW_CHANGE (optional feature); 5-7 read 0.
  - Unselected or unmapped reads load 0 and have no side effects.
- Read: on rd_en with a selected address, rdata loads the addressed word on the next rising edge, giving one-cycle latency. Without rd_en, rdata holds its value.
- Clear-on-read: a read of offset 2 clears exactly the bits it returned. A flag newly set in the same cycle wins and stays set.
- Write: we at offset 2 clears the bits where wdata is 1. A same-cycle new edge wins. Writes to other offsets are ignored.
- rd_en and we in the same cycle: the read captures the pre-clear value, then both clears apply.
- key_irq is |KEY_EDGE as it stands after the current cycle's update, registered, so it drops one cycle after the clearing access.

Optional Feature:
- Macro: SWKEY_SW_CHANGE_EN
- Defined:
  - A 10-bit sticky SW_CHANGE register sets bit i on any debounced sw[i] transition.
  - Offset 4 reads it and clears it on read, with the same new-event-wins rule as KEY_EDGE.
  - STATUS bit1 = |SW_CHANGE.
- Undefined: no SW_CHANGE storage; offset 4 and STATUS bit1 read 0.

Test Plan:
- Reset: assert reset 3 cycles with sw=10'b1010101010, key=4'b1111 -> rdata=0, key_irq=0. Then read offset 1 -> 0.
- Switch debounce (DEBOUNCE_CYCLES=4): set sw=10'b1010101010 and hold -> a SW_STATE read issued at cycle 5 after the change returns 0, at cycle 6 returns 32'h2AA.
- Glitch rejection (DEBOUNCE_CYCLES=4): pulse key[0]=0 for 3 cycles -> KEY_STATE stays 0 and KEY_EDGE stays 0. Pulse for 8 cycles -> KEY_STATE bit0=1 and KEY_EDGE=1, key_irq=1.
- Clear-on-read: with KEY_EDGE=4'b0101, read offset 2 -> rdata=5, KEY_EDGE=0, key_irq=0 one cycle later. A second read returns 0.
- Collision: key[2] press debounces in the same cycle as a read of offset 2 returning 4'b0001 -> rdata=1, then KEY_EDGE=4'b0100 and key_irq stays 1. A write of wdata=4 to offset 2 then clears it.
- Decode: read 32'h000000E0 and offset 6 -> rdata=0, no flags changed. With SWKEY_SW_CHANGE_EN, toggle sw every 20 cycles -> offset 4 shows all ten change bits set, and reads 0 after a read.
